// File: rtl/test_pattern_checker_pkg.sv
// Shared types and constants for the test-pattern checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_pattern_pkg;

  localparam int PATTERN_W  = 23;
  localparam int TEST_IDX_W = 5;

  typedef logic [PATTERN_W-1:0]  pattern_t;
  typedef logic [TEST_IDX_W-1:0] test_idx_t;

  // The generator cycles through these four words, keyed by the low two
  // bits of the test index.
  localparam pattern_t PAT_0 = 23'h7ABCDE;
  localparam pattern_t PAT_1 = 23'h712345;
  localparam pattern_t PAT_2 = 23'h767890;
  localparam pattern_t PAT_3 = 23'h7BBCCD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the low two index bits select the word, so callers pass idx[1:0].
  function automatic pattern_t expected_pattern(input logic [1:0] idx);
    pattern_t p;
    case (idx)
      2'b00:   p = PAT_0;
      2'b01:   p = PAT_1;
      2'b10:   p = PAT_2;
      default: p = PAT_3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/test_pattern_checker_if.sv
// Receive-side pattern stream: data plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: beat transfers when rx_valid & rx_ready.
interface test_pattern_checker_if;
  import test_pattern_pkg::*;

  pattern_t rx_data;
  logic     rx_valid;
  logic     rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/test_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Latency: count reflects clear/inc one cycle after they are asserted.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] count_q;
  logic [ERR_W-1:0] count_d;

  // Next count: clear first, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/test_pattern_checker.sv
// Checks a received pattern stream against the expected per-test words and reports pass/fail.
// Latency: results update one cycle after each beat; done follows the final beat by one cycle.
// Backpressure: rx_ready is high only in RUN (from registered state), one beat per cycle.
module test_pattern_checker
  import test_pattern_pkg::*;
#(
  parameter int WORDS_PER_TEST = 16,
  parameter int NUM_TESTS      = 32,
  parameter int ERR_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  test_pattern_checker_if.slave rx,
  output logic [TEST_IDX_W-1:0] current_test,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  first_err_valid,
  output logic [TEST_IDX_W-1:0] first_err_test,
  output logic [PATTERN_W-1:0]  first_err_data
);

  // A single word per test still needs a 1-bit counter to stay legal.
  localparam int        WC_W      = (WORDS_PER_TEST > 1) ? $clog2(WORDS_PER_TEST) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_TEST - 1);
  localparam test_idx_t LAST_TEST = TEST_IDX_W'(NUM_TESTS - 1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  test_idx_t         current_test_q, current_test_d;
  logic              first_err_valid_q, first_err_valid_d;
  test_idx_t         first_err_test_q, first_err_test_d;
  pattern_t          first_err_data_q, first_err_data_d;

  logic              xfer;
  logic              mismatch;
  logic              clear_run;

  assign rx.rx_ready = (state_q == ST_RUN);
  assign xfer        = rx.rx_valid & rx.rx_ready;
  assign mismatch    = xfer && (rx.rx_data != expected_pattern(current_test_q[1:0]));

  // Next-state, counter stepping and first-error capture.
  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    current_test_d    = current_test_q;
    first_err_valid_d = first_err_valid_q;
    first_err_test_d  = first_err_test_q;
    first_err_data_d  = first_err_data_q;
    clear_run         = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d           = ST_RUN;
          word_cnt_d        = '0;
          current_test_d    = '0;
          first_err_valid_d = 1'b0;
          first_err_test_d  = '0;
          first_err_data_d  = '0;
          clear_run         = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (mismatch && !first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_test_d  = current_test_q;
            first_err_data_d  = rx.rx_data;
          end
          if (word_cnt_q == WC_LAST) begin
            word_cnt_d     = '0;
            current_test_d = current_test_q + 1'b1;
            if (current_test_q == LAST_TEST) begin
              state_d = ST_DONE;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and run-tracking registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      word_cnt_q        <= '0;
      current_test_q    <= '0;
      first_err_valid_q <= 1'b0;
      first_err_test_q  <= '0;
      first_err_data_q  <= '0;
    end else begin
      state_q           <= state_d;
      word_cnt_q        <= word_cnt_d;
      current_test_q    <= current_test_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_test_q  <= first_err_test_d;
      first_err_data_q  <= first_err_data_d;
    end
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_run),
    .inc   (mismatch),
    .count (err_count)
  );

  assign current_test    = current_test_q;
  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = done && (err_count == '0);
  assign first_err_valid = first_err_valid_q;
  assign first_err_test  = first_err_test_q;
  assign first_err_data  = first_err_data_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Scoreboard bench: two checkers (16-bit and 2-bit error counters) fed the same stream.
// Latency: expectations are popped when done rises, one cycle after the final beat.
// Backpressure: stimulus holds each beat until rx_ready is seen.
module tb_test_pattern_checker;

  logic clk;
  logic rst_n;
  logic start;
  int   cyc;
  int   checks;
  int   errors;

  test_pattern_checker_if rx_if();
  test_pattern_checker_if sat_if();
  assign sat_if.rx_data  = rx_if.rx_data;
  assign sat_if.rx_valid = rx_if.rx_valid;

  logic [4:0]  cur16, ft16, cur2, ft2;
  logic        busy16, done16, pass16, fev16;
  logic        busy2, done2, pass2, fev2;
  logic [15:0] err16;
  logic [1:0]  err2;
  logic [22:0] fd16, fd2;

  test_pattern_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(rx_if.slave),
    .current_test(cur16), .busy(busy16), .done(done16), .pass(pass16),
    .err_count(err16), .first_err_valid(fev16), .first_err_test(ft16),
    .first_err_data(fd16)
  );

  test_pattern_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(sat_if.slave),
    .current_test(cur2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fev2), .first_err_test(ft2),
    .first_err_data(fd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int err;
    bit pas;
    bit fev;
    int ft;
    int fd;
  } res_t;

  res_t q16[$];
  res_t q2[$];

  // Hand-written expectations per stimulus mode:
  // 0 clean, 1 single error, 2 two errors, 3 all-zero words.
  logic [22:0] pat[4]      = '{23'h7ABCDE, 23'h712345, 23'h767890, 23'h7BBCCD};
  int          exp_err16[4] = '{0, 1, 2, 512};
  int          exp_err2[4]  = '{0, 1, 2, 3};
  bit          exp_fev[4]   = '{0, 1, 1, 1};
  int          exp_ft[4]    = '{0, 5, 2, 0};
  int          exp_fd[4]    = '{0, 'h712344, 'h767891, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input int cyc_now, input int last_xfer,
                              input int beats, input int err, input bit pas, input bit fev,
                              input int ft, input int fd, ref res_t q[$]);
    res_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done actual=done required=no_done", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_done_latency"}, cyc_now, last_xfer + 1);
      chk({tag, "_beats"}, beats, 512);
      chk({tag, "_err_count"}, err, e.err);
      chk({tag, "_pass"}, pas, e.pas);
      chk({tag, "_first_err_valid"}, fev, e.fev);
      chk({tag, "_first_err_test"}, ft, e.ft);
      chk({tag, "_first_err_data"}, fd, e.fd);
    end
  endtask

  int  bc16, last16, bc2, last2;
  bit  dprev16, dprev2;

  // Monitor for the default checker: per-beat test index and end-of-run results.
  always @(negedge clk) begin
    if (!rst_n) begin
      bc16 = 0;
      dprev16 = 0;
    end else begin
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        chk("cur_test16", cur16, bc16 / 16);
        bc16++;
        last16 = cyc;
      end
      if (done16 && !dprev16) begin
        check_result("d16", cyc, last16, bc16, int'(err16), pass16, fev16,
                     int'(ft16), int'(fd16), q16);
        chk("d16_rx_ready_at_done", rx_if.rx_ready, 0);
        bc16 = 0;
      end
      dprev16 = done16;
    end
  end

  // Monitor for the 2-bit saturating checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      bc2 = 0;
      dprev2 = 0;
    end else begin
      if (sat_if.rx_valid && sat_if.rx_ready) begin
        bc2++;
        last2 = cyc;
      end
      if (done2 && !dprev2) begin
        check_result("d2", cyc, last2, bc2, int'(err2), pass2, fev2,
                     int'(ft2), int'(fd2), q2);
        bc2 = 0;
      end
      dprev2 = done2;
    end
  end

  function automatic logic [22:0] beat_data(input int mode, input int b);
    int t;
    int w;
    logic [22:0] d;
    t = b / 16;
    w = b % 16;
    d = pat[t % 4];
    case (mode)
      1: if (t == 5 && w == 3) d = 23'h712344;
      2: begin
        if (t == 2 && w == 0) d = 23'h767891;
        if (t == 9 && w == 7) d = 23'h000000;
      end
      3: d = 23'h000000;
      default: ;
    endcase
    return d;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy16, 1);
    chk("start_rx_ready", rx_if.rx_ready, 1);
    chk("start_err_cleared", err16, 0);
    chk("start_fev_cleared", fev16, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [22:0] d, input bit gaps, output bit ok);
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        rx_if.rx_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rx_if.rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_run(input int mode, input bit gaps, input int nbeats);
    res_t e;
    bit ok;
    bit seen;
    if (nbeats == 512) begin
      e.err = exp_err16[mode]; e.pas = (exp_err16[mode] == 0); e.fev = exp_fev[mode];
      e.ft = exp_ft[mode]; e.fd = exp_fd[mode];
      q16.push_back(e);
      e.err = exp_err2[mode]; e.pas = (exp_err2[mode] == 0);
      q2.push_back(e);
    end
    pulse_start();
    for (int b = 0; b < nbeats; b++) begin
      send_beat(beat_data(mode, b), gaps, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout actual=no_ready required=ready beat=%0d", b);
        rx_if.rx_valid = 1'b0;
        return;
      end
    end
    rx_if.rx_valid = 1'b0;
    if (nbeats == 512) begin
      seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (done16) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=0 required=1");
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, rx_if.rx_ready, 0);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_done"}, done16, 0);
    chk({tag, "_pass"}, pass16, 0);
    chk({tag, "_current_test"}, cur16, 0);
    chk({tag, "_err_count"}, err16, 0);
    chk({tag, "_err_count_sat"}, err2, 0);
    chk({tag, "_first_err_valid"}, fev16, 0);
    chk({tag, "_first_err_test"}, ft16, 0);
    chk({tag, "_first_err_data"}, fd16, 0);
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    // Clean back-to-back run from IDLE.
    do_run(0, 1'b0, 512);

    // rx_valid while in DONE must not be counted.
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 23'h000000;
    repeat (5) @(posedge clk);
    #1 rx_if.rx_valid = 1'b0;
    @(negedge clk);
    chk("done_hold_err", err16, 0);
    chk("done_hold_done", done16, 1);
    chk("done_hold_pass", pass16, 1);
    @(posedge clk); #1;

    do_run(1, 1'b0, 512);   // single error, start from DONE
    do_run(2, 1'b0, 512);   // two errors
    do_run(3, 1'b0, 512);   // all zero: 512 errors / saturates at 3
    do_run(0, 1'b1, 512);   // gaps plus start pulses during RUN

    // Abort a run after 100 beats with a one-cycle reset.
    do_run(1, 1'b0, 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    @(posedge clk); #1;

    do_run(0, 1'b0, 512);   // clean after reset
    do_run(2, 1'b1, 512);   // errors, restarted from DONE
    do_run(0, 1'b0, 512);   // restart from DONE clears the previous errors

    repeat (3) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/test_pattern_checker.md
# test_pattern_checker

Receive-side checker for the 23-bit test-pattern stream. It accepts pattern words over a valid/ready handshake and steps through the test sequence on its own. Each word is compared against the expected pattern for the current test index. The block accumulates a saturating error count and reports pass/fail when the full sequence completes. It sits at the far end of the link under test, opposite the pattern generator.

## Interface
- WORDS_PER_TEST, 16, beats checked per test index (≥1)
- NUM_TESTS, 32, test indices per run (1..32)
- ERR_W, 16, error counter width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- rx_data  in  23  received pattern word
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  checker accepts a beat; a beat transfers when rx_valid & rx_ready
- current_test  out  5  test index currently being checked
- busy  out  1  state == RUN
- done  out  1  state == DONE
- pass  out  1  done & (err_count == 0)
- err_count  out  ERR_W  mismatching beats this run, saturating
- first_err_valid  out  1  at least one mismatch captured this run
- first_err_test  out  5  current_test of the first mismatching beat
- first_err_data  out  23  rx_data of the first mismatching beat

## Operation
- Expected word for index i, by i[1:0]: 00→0x7ABCDE, 01→0x712345, 10→0x767890, 11→0x7BBCCD.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: rx_ready=0. start moves to RUN and clears current_test, word_cnt, err_count, first_err_*.
- RUN: rx_ready=1. Each transferred beat is compared with the full 23 bits against expected(current_test).
  - Mismatch: err_count+1, saturating at 2^ERR_W−1. If first_err_valid=0, capture test/data and set first_err_valid.
  - word_cnt increments. At WORDS_PER_TEST−1 it wraps to 0 and current_test increments.
  - On the last beat of test NUM_TESTS−1, go to DONE.
- start during RUN is ignored.
- rx_valid without a transfer (state ≠ RUN) is ignored; no counter changes.
- DONE: rx_ready=0. done, pass and the captured results hold. start re-enters RUN with everything cleared, as from IDLE.
- Reset values: state IDLE; rx_ready 0, busy 0, done 0, pass 0, current_test 0, err_count 0, first_err_valid 0, first_err_test 0, first_err_data 0.
- Reset mid-run aborts immediately to those values; no partial results are retained.

## Timing
- rx_ready is decoded from the registered state only; no combinational path from rx_valid.
- A transfer in cycle N updates err_count, first_err_* and current_test at edge N+1.
- The final beat in cycle N gives done=1 at N+1. err_count at that point already includes the final beat.
- rx_ready drops at N+1, so no beat is accepted after the final one.
- start in cycle N gives busy=1 and rx_ready=1 at N+1.
- Back-to-back beats are accepted at one per cycle. Gaps in rx_valid stall the counters with no penalty.
- Minimum run length is NUM_TESTS·WORDS_PER_TEST transfer cycles, plus 1 cycle to DONE.

## Structure
- Package test_pattern_pkg:
  - PATTERN_W = 23 and TEST_IDX_W = 5.
  - The four pattern constants.
  - A function expected_pattern(idx) returning the word for idx[1:0].
  - The FSM state enum.
- One sub-module is natural: sat_counter (parameter ERR_W, clear, inc, count out), used for err_count.
- The FSM, word/test counters and first-error capture live in the top.

## Test plan
- Clean run, defaults: start, then 512 correct beats back-to-back → done at cycle after beat 512, pass=1, err_count=0, first_err_valid=0, current_test wrapped through 31.
- Single error: corrupt test 5, word 3 with 0x712344 (expected 0x712345) → err_count=1, first_err_test=5, first_err_data=0x712344, pass=0.
- Two errors at test 2 and test 9 → err_count=2; first_err_* still reports test 2.
- Saturation with ERR_W=2: all beats 0x000000 → err_count=3 at done, pass=0, first_err_test=0.
- Random rx_valid gaps (≈50% duty), plus start pulses during RUN → results identical to the clean run; start in RUN has no effect.
- Reset at beat 100 asserted for 1 cycle → all outputs at reset values next edge. A new start plus a clean 512 beats → pass=1. Then start from DONE restarts with counts cleared.
